// File: rtl/frac_div_sched_pkg.sv
// Shared types and constants for the fractional period scheduler.
package frac_div_sched_pkg;

  localparam int DW_DEF  = 8;
  localparam int FW_DEF  = 8;
  localparam int N_MIN   = 2;

  // Active configuration loaded by reset: plain divide-by-2.
  localparam int RST_N   = 2;
  localparam int RST_NUM = 0;
  localparam int RST_DEN = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/frac_div_acc.sv
// Dual-modulus accumulator: picks N or N+1 for the next period and holds the fractional residue.
module frac_div_acc #(
  parameter int DW = 8,
  parameter int FW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step_i,
  input  logic          clr_i,
  input  logic [DW-1:0] n_i,
  input  logic [FW-1:0] num_i,
  input  logic [FW-1:0] den_i,
  output logic [DW-1:0] len_o
);

  logic [FW-1:0] acc_q, acc_d, base;
  logic [FW:0]   sum;

  // clr_i starts the sequence from a zero residue (run start or new config).
  always_comb begin
    base = clr_i ? '0 : acc_q;
    sum  = {1'b0, base} + {1'b0, num_i};
    if (sum >= {1'b0, den_i}) begin
      len_o = n_i + DW'(1);
      acc_d = FW'(sum - {1'b0, den_i});
    end else begin
      len_o = n_i;
      acc_d = sum[FW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (step_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/frac_div_sched.sv
// Fractional clock-divider scheduler: FSM, period counter, config handshake and output registers.
module frac_div_sched
  import frac_div_sched_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int FW = FW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [DW-1:0] cfg_int,
  input  logic [FW-1:0] cfg_num,
  input  logic [FW-1:0] cfg_den,
  output logic          cfg_err,
  output logic          clk_en,
  output logic          clk_out,
  output logic [DW-1:0] cur_len,
  output logic          busy
);

  localparam logic [DW-1:0] N_MAX = {{(DW-1){1'b1}}, 1'b0};

  state_e        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [DW-1:0] n_q, n_d, pn_q, pn_d;
  logic [FW-1:0] num_q, num_d, den_q, den_d, pnum_q, pnum_d, pden_q, pden_d;
  logic          pend_q, pend_d, err_q, err_d, out_q, out_d;
  logic          step, clr, use_pend, hs, cfg_ok, boundary;
  logic [DW-1:0] acc_len, sel_n;
  logic [FW-1:0] sel_num, sel_den;

  // Handshake: a transfer happens on a cycle with cfg_valid && cfg_ready; ready only
  // drops while a config taken during a run waits for the next period boundary.
  assign cfg_ready = (state_q == IDLE) || !pend_q;
  assign hs        = cfg_valid && cfg_ready;
  assign cfg_ok    = (cfg_int >= DW'(N_MIN)) && (cfg_int <= N_MAX) &&
                     (cfg_den != '0) && (cfg_num < cfg_den);
  assign boundary  = (state_q != IDLE) && (cnt_q == len_q - DW'(1));

  assign sel_n   = use_pend ? pn_q   : n_q;
  assign sel_num = use_pend ? pnum_q : num_q;
  assign sel_den = use_pend ? pden_q : den_q;

  frac_div_acc #(.DW(DW), .FW(FW)) u_acc (
    .clk    (clk),
    .rst    (rst),
    .step_i (step),
    .clr_i  (clr),
    .n_i    (sel_n),
    .num_i  (sel_num),
    .den_i  (sel_den),
    .len_o  (acc_len)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    n_d      = n_q;
    num_d    = num_q;
    den_d    = den_q;
    pend_d   = pend_q;
    pn_d     = pn_q;
    pnum_d   = pnum_q;
    pden_d   = pden_q;
    err_d    = 1'b0;
    step     = 1'b0;
    clr      = 1'b0;
    use_pend = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
          cnt_d   = '0;
          step    = 1'b1;
          clr     = 1'b1;
          len_d   = acc_len;
        end
      end
      RUN, DRAIN: begin
        if (boundary) begin
          // A waiting config takes over exactly here, with a fresh residue.
          if (pend_q) begin
            use_pend = 1'b1;
            clr      = 1'b1;
            pend_d   = 1'b0;
            n_d      = pn_q;
            num_d    = pnum_q;
            den_d    = pden_q;
          end
          cnt_d = '0;
          if (en) begin
            state_d = RUN;
            step    = 1'b1;
            len_d   = acc_len;
          end else begin
            state_d = IDLE;
            len_d   = '0;
          end
        end else begin
          cnt_d   = cnt_q + DW'(1);
          state_d = en ? RUN : DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (hs) begin
      if (!cfg_ok) begin
        err_d = 1'b1;
      end else if (state_q == IDLE) begin
        n_d   = cfg_int;
        num_d = cfg_num;
        den_d = cfg_den;
      end else begin
        pend_d = 1'b1;
        pn_d   = cfg_int;
        pnum_d = cfg_num;
        pden_d = cfg_den;
      end
    end

    out_d = (state_d != IDLE) && (cnt_d < (len_d >> 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      n_q     <= DW'(RST_N);
      num_q   <= FW'(RST_NUM);
      den_q   <= FW'(RST_DEN);
      pend_q  <= 1'b0;
      pn_q    <= '0;
      pnum_q  <= '0;
      pden_q  <= '0;
      err_q   <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      n_q     <= n_d;
      num_q   <= num_d;
      den_q   <= den_d;
      pend_q  <= pend_d;
      pn_q    <= pn_d;
      pnum_q  <= pnum_d;
      pden_q  <= pden_d;
      err_q   <= err_d;
      out_q   <= out_d;
    end
  end

  assign clk_en  = boundary;
  assign clk_out = out_q;
  assign cur_len = len_q;
  assign busy    = (state_q != IDLE);
  assign cfg_err = err_q;

endmodule

// File: tb/tb_frac_div_sched.sv
// Bench for frac_div_sched: period lengths predicted from the closed-form N + floor((k+1)num/den) - floor(k num/den).
module tb_frac_div_sched;

  logic       clk = 1'b0;
  logic       rst, en, cfg_valid, cfg_ready, cfg_err, clk_en, clk_out, busy;
  logic [7:0] cfg_int, cfg_num, cfg_den, cur_len;

  int passed = 0;
  int total  = 0;

  // Reference model state: active config and period index since last clear.
  int mn, mnum, mden, mk;
  logic [31:0] exp_q[$];
  int last_cyc, sum;

  frac_div_sched #(.DW(8), .FW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_int   (cfg_int),
    .cfg_num   (cfg_num),
    .cfg_den   (cfg_den),
    .cfg_err   (cfg_err),
    .clk_en    (clk_en),
    .clk_out   (clk_out),
    .cur_len   (cur_len),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int model_len();
    return mn + ((mk + 1) * mnum) / mden - (mk * mnum) / mden;
  endfunction

  task automatic set_cfg(input int n, input int num, input int den, input bit ok);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_int   = 8'(n);
    cfg_num   = 8'(num);
    cfg_den   = 8'(den);
    chk("idle_ready", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("idle_cfg_err", cfg_err, ok ? 0 : 1);
    if (ok) begin
      mn = n; mnum = num; mden = den;
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    en = 1'b1;
    mk = 0;
  endtask

  // drop_at < 0: release en on the clk_en cycle, ending the run at this boundary.
  task automatic run_period(input int drop_at, input bit offer, input int on, input int onum,
                            input int oden, input bit o_ok);
    int exp_len, cyc, high;
    bit seen;
    exp_q.push_back(model_len());
    mk++;
    exp_len = exp_q.pop_front();
    cyc = 0; high = 0; seen = 1'b0;
    while (!seen && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("cur_len_start", cur_len, exp_len);
      high += int'(clk_out);
      seen = clk_en;
      if (offer && cyc == 1) begin
        chk("ready_before_offer", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_int = 8'(on); cfg_num = 8'(onum); cfg_den = 8'(oden);
      end
      if (offer && cyc == 2) begin
        cfg_valid = 1'b0;
        chk("run_cfg_err", cfg_err, o_ok ? 0 : 1);
        chk("ready_after_offer", cfg_ready, o_ok ? 0 : 1);
      end
      if (offer && cyc == 3 && !seen) chk("cfg_err_one_cycle", cfg_err, 0);
      if (offer && o_ok && seen && cyc > 2) chk("ready_held_to_boundary", cfg_ready, 0);
      if (cyc == drop_at || (drop_at < 0 && seen)) en = 1'b0;
    end
    chk("period_len", cyc, exp_len);
    chk("high_cycles", high, exp_len >> 1);
    chk("cur_len_end", cur_len, exp_len);
    last_cyc = cyc;
    if (offer && o_ok) begin
      mn = on; mnum = onum; mden = oden; mk = 0;
    end
  endtask

  task automatic run_n(input int count);
    for (int p = 0; p < count; p++) run_period((p == count - 1) ? -1 : 0, 0, 0, 0, 0, 0);
  endtask

  task automatic stop_check();
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_cur_len", cur_len, 0);
    chk("idle_clk_en", clk_en, 0);
    chk("idle_clk_out", clk_out, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    cfg_int = '0; cfg_num = '0; cfg_den = '0;
    mn = 2; mnum = 0; mden = 1; mk = 0;
    repeat (2) @(negedge clk);
    chk("rst_clk_en", clk_en, 0);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_cur_len", cur_len, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    rst = 1'b0;

    // Integer divide by 4.
    set_cfg(4, 0, 1, 1);
    start_run();
    run_n(4);
    stop_check();

    // Divide by 3.5.
    set_cfg(3, 1, 2, 1);
    start_run();
    run_n(6);
    stop_check();

    // 7.3: ten periods span 73 cycles.
    set_cfg(7, 3, 10, 1);
    start_run();
    sum = 0;
    for (int p = 0; p < 10; p++) begin
      run_period((p == 9) ? -1 : 0, 0, 0, 0, 0, 0);
      sum += last_cyc;
    end
    chk("sum_10_periods", sum, 73);
    stop_check();

    // Runtime switch 4 -> 6 offered mid-period.
    set_cfg(4, 0, 1, 1);
    start_run();
    run_period(0, 0, 0, 0, 0, 0);
    run_period(0, 1, 6, 0, 1, 1);
    run_n(2);
    stop_check();

    // Rejected offers while running leave timing untouched.
    set_cfg(4, 0, 1, 1);
    start_run();
    run_period(0, 1, 1, 0, 1, 0);
    run_period(0, 1, 4, 0, 0, 0);
    run_period(0, 1, 4, 5, 5, 0);
    run_n(1);
    stop_check();

    // N range edges: 255 rejected, 254 accepted and yields 254/255-cycle periods.
    set_cfg(255, 0, 1, 0);
    set_cfg(254, 1, 2, 1);
    start_run();
    run_n(2);
    stop_check();

    // en dropped at cnt=1 of a 5-cycle period: the period still completes.
    set_cfg(5, 0, 1, 1);
    start_run();
    run_period(2, 0, 0, 0, 0, 0);
    stop_check();

    // Randomized ratios.
    for (int r = 0; r < 4; r++) begin
      int n, num, den;
      n   = $urandom_range(2, 12);
      den = $urandom_range(1, 9);
      num = $urandom_range(0, den - 1);
      set_cfg(n, num, den, 1);
      start_run();
      run_n(den + 1);
      stop_check();
    end

    // Reset mid-period aborts at once and restores divide-by-2.
    set_cfg(4, 0, 1, 1);
    start_run();
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_clk_out", clk_out, 1);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    chk("mid_rst_cur_len", cur_len, 0);
    chk("mid_rst_clk_out", clk_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_clk_en", clk_en, 0);
    rst = 1'b0;
    mn = 2; mnum = 0; mden = 1;
    start_run();
    run_n(2);
    stop_check();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
